// File: rtl/gain_split.sv
// rtl/gain_split.sv - splits combined ISI value z into coarse index x and fine offset y via restoring division.
// Optional err output guarded by GAIN_SPLIT_ERR_EN.
module gain_split #(
  parameter int bit_isi = 8,
  parameter int g       = 7,
  parameter int bit_g   = $clog2(g)
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [bit_isi-1:0] isi_z,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [bit_isi-1:0] isi_x,
  output logic [bit_g-1:0]   isi_y,
  output logic               out_valid,
  input  logic               out_ready
`ifdef GAIN_SPLIT_ERR_EN
  ,
  output logic               err
`endif
);

  localparam int                 CW       = (bit_isi > 1) ? $clog2(bit_isi) : 1;
  localparam logic [CW-1:0]      CNT_INIT = CW'(bit_isi - 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [bit_isi-1:0] ONE_X    = bit_isi'(1);
  localparam logic [bit_g:0]     G_T      = (bit_g + 1)'(g);

  typedef enum logic [1:0] {IDLE, DIV, FIN, DONE} state_t;

  state_t             state_q;
  logic [bit_isi-1:0] d_q;
  logic [bit_g-1:0]   rem_q;
  logic [bit_isi-1:0] quot_q;
  logic [CW-1:0]      cnt_q;
  logic               zero_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [bit_isi-1:0] isi_x_q;
  logic [bit_g-1:0]   isi_y_q;
`ifdef GAIN_SPLIT_ERR_EN
  logic               err_q;
`endif

  logic [bit_g:0]     t_d;
  logic               take_d;
  logic [bit_g-1:0]   rem_d;
  logic [bit_isi-1:0] quot_d;

  // One restoring step: t < g whenever it is not subtracted, so it always fits in rem.
  always_comb begin
    t_d    = {rem_q, d_q[bit_isi-1]};
    take_d = (t_d >= G_T);
    rem_d  = take_d ? bit_g'(t_d - G_T) : t_d[bit_g-1:0];
    quot_d = {quot_q[bit_isi-2:0], take_d};
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      d_q         <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      isi_x_q     <= '0;
      isi_y_q     <= '0;
`ifdef GAIN_SPLIT_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // Coming back from DONE, in_ready rises one cycle after the output handshake.
          if (!in_ready_q) begin
            in_ready_q <= 1'b1;
          end else if (in_valid) begin
            zero_q     <= (isi_z == '0);
            d_q        <= (isi_z == '0) ? '0 : isi_z - ONE_X;
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= CNT_INIT;
            in_ready_q <= 1'b0;
            state_q    <= DIV;
          end
        end
        DIV: begin
          d_q    <= d_q << 1;
          rem_q  <= rem_d;
          quot_q <= quot_d;
          if (cnt_q == '0) begin
            state_q <= FIN;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        FIN: begin
          if (zero_q) begin
            isi_x_q <= '0;
            isi_y_q <= '0;
          end else begin
            isi_x_q <= quot_q + ONE_X;
            isi_y_q <= rem_q;
          end
`ifdef GAIN_SPLIT_ERR_EN
          err_q       <= zero_q;
`endif
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
`ifdef GAIN_SPLIT_ERR_EN
            err_q       <= 1'b0;
`endif
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign isi_x     = isi_x_q;
  assign isi_y     = isi_y_q;
`ifdef GAIN_SPLIT_ERR_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_gain_split.sv
// tb/tb_gain_split.sv - scoreboard bench for gain_split against an arithmetic divide/modulo model.
module tb_gain_split;

  localparam int BI  = 8;
  localparam int G   = 7;
  localparam int BG  = $clog2(G);
  localparam int LAT = BI + 1;

  logic          clk;
  logic          clr_n;
  logic [BI-1:0] isi_z;
  logic          in_valid;
  logic          in_ready;
  logic [BI-1:0] isi_x;
  logic [BG-1:0] isi_y;
  logic          out_valid;
  logic          out_ready;
`ifdef GAIN_SPLIT_ERR_EN
  logic          err;
`endif

  gain_split #(.bit_isi(BI), .g(G)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .isi_z    (isi_z),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .isi_x    (isi_x),
    .isi_y    (isi_y),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef GAIN_SPLIT_ERR_EN
    ,
    .err      (err)
`endif
  );

  typedef struct {
    int x;
    int y;
    int e;
    int hs;
  } exp_t;

  exp_t sbq[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   mode = 0;  // 0: random out_ready, 1: hold low, 2: hold high

  logic          last_valid = 1'b0;
  logic [BI-1:0] last_x = '0;
  logic [BG-1:0] last_y = '0;
  exp_t          mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    total_cnt++;
    if (got == want) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
  endtask

  // Reference: z = (x-1)*g + 1 + y  =>  x = (z-1)/g + 1, y = (z-1)%g; z==0 is the error case.
  function automatic exp_t model(input int z);
    exp_t r;
    if (z == 0) begin
      r.x = 0; r.y = 0; r.e = 1;
    end else begin
      r.x = (z - 1) / G + 1; r.y = (z - 1) % G; r.e = 0;
    end
    r.hs = 0;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge following the input handshake.
  task automatic send(input int z);
    int   n;
    exp_t e;
    isi_z    = BI'(z);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e    = model(z);
    e.hs = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (mode == 1) out_ready = 1'b0;
      else if (mode == 2) out_ready = 1'b1;
      else out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  always @(negedge clk) begin
    if (clr_n) begin
      if (out_valid) chk("no_overlap_in_ready", int'(in_ready), 0);
      if (out_valid && !last_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("isi_x", int'(isi_x), mon_e.x);
          chk("isi_y", int'(isi_y), mon_e.y);
          chk("latency", cyc - mon_e.hs, LAT);
`ifdef GAIN_SPLIT_ERR_EN
          chk("err", int'(err), mon_e.e);
`endif
        end
      end else if (out_valid && last_valid) begin
        chk("hold_x", int'(isi_x), int'(last_x));
        chk("hold_y", int'(isi_y), int'(last_y));
      end
    end
    last_valid = out_valid;
    last_x     = isi_x;
    last_y     = isi_y;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int zr;
    clr_n    = 1'b0;
    in_valid = 1'b0;
    isi_z    = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_isi_x", int'(isi_x), 0);
    chk("rst_isi_y", int'(isi_y), 0);
    clr_n = 1'b1;
    @(negedge clk);

    // Directed boundaries, the round-trip value, and the error case followed by a normal input.
    send(1);   gap();
    send(7);   gap();
    send(8);   gap();
    send(255); gap();
    send((3 - 1) * G + 1 + 4); gap();
    send(0);
    send(50);  gap();

    // Backpressure: outputs must hold, then in_ready returns two edges after release.
    n = 0;
    while (sbq.size() != 0 && n < 200) begin @(negedge clk); n++; end
    mode = 1;
    send(100);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("hold_out_valid_seen", int'(out_valid), 1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_in_ready_low", int'(in_ready), 0);
      chk("hold_out_valid_high", int'(out_valid), 1);
    end
    mode = 2;
    @(negedge clk);
    chk("release_pre_valid", int'(out_valid), 1);
    @(negedge clk);
    chk("release_valid_drop", int'(out_valid), 0);
    chk("release_in_ready_low", int'(in_ready), 0);
    @(negedge clk);
    chk("release_in_ready_high", int'(in_ready), 1);
    mode = 0;

    // Abort mid-division: reset clears outputs at once, next result is clean.
    send(255);
    repeat (3) @(negedge clk);
    clr_n = 1'b0;
    #1;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_isi_x", int'(isi_x), 0);
    chk("abort_isi_y", int'(isi_y), 0);
    sbq.delete();
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    send(19); gap();

    // Full sweep, then random values.
    for (int z = 1; z < 256; z++) begin
      send(z);
      gap();
    end
    for (int i = 0; i < 40; i++) begin
      zr = $urandom_range(0, 255);
      send(zr);
      gap();
    end

    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 2000) begin @(negedge clk); n++; end
    chk("drain_scoreboard", sbq.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
